// File: rtl/pc_pkg.sv
// Shared definitions for the miniRISC program-counter unit:
// next-PC select encoding and the return-stack pointer-width helper.
package pc_pkg;

    // Which source the PC register loads on the next falling edge.
    typedef enum logic [2:0] {
        NPC_SEQ  = 3'd0,
        NPC_BR   = 3'd1,
        NPC_JMP  = 3'd2,
        NPC_CALL = 3'd3,
        NPC_RET  = 3'd4,
        NPC_HOLD = 3'd5
    } npc_sel_e;

    // Pointer width for a return stack of the given (power-of-two) depth.
    // A depth of one would give a zero-width pointer, so it is floored at 1.
    function automatic int ras_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Pointer width for the default eight-entry return stack.
    localparam int RAS_PTR_W_DEFAULT = ras_ptr_w(8);

endpackage

// File: rtl/pc_unit_ras_if.sv
// Control/status bundle between the decode/branch unit and the PC unit.
// The decode side is the master; the PC unit is the slave.
interface pc_unit_ras_if #(
    parameter int ADDR_W = 32
);
    logic              HLT;
    logic              BR_TAKEN;
    logic [ADDR_W-1:0] BR_TARGET;
    logic              JMP;
    logic              CALL;
    logic [ADDR_W-1:0] J_TARGET;
    logic              RET;
    logic [ADDR_W-1:0] PC_OUT;
    logic              RAS_EMPTY;
    logic              RAS_FULL;
    logic              RAS_OVF;
    logic              RAS_UNF;

    // Decode/branch side: issues redirect requests, observes PC and stack state.
    modport master (
        output HLT, BR_TAKEN, BR_TARGET, JMP, CALL, J_TARGET, RET,
        input  PC_OUT, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
    );

    // PC unit side: consumes requests, drives PC and stack state.
    modport slave (
        input  HLT, BR_TAKEN, BR_TARGET, JMP, CALL, J_TARGET, RET,
        output PC_OUT, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
    );
endinterface

// File: rtl/ras_stack.sv
// Circular return-address stack. Pushing while full silently overwrites the
// oldest entry; popping while empty leaves pointer and occupancy alone.
// Push and pop are expected to be mutually exclusive (the caller arbitrates).
module ras_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 8
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [ADDR_W-1:0] i_push_data,
    output logic [ADDR_W-1:0] o_pop_data,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_ovf,
    output logic              o_unf
);
    localparam int PTR_W = ras_ptr_w(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  r_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  w_ptr_prev;
    logic              w_do_pop;

    // The pointer always names the next free slot, so the top of stack sits
    // one below it; with a power-of-two depth the wrap is natural overflow.
    assign w_ptr_prev = r_ptr - PTR_W'(1);
    assign o_pop_data = r_mem[w_ptr_prev];
    assign o_empty    = (r_count == '0);
    assign o_full     = (r_count == CNT_W'(RAS_DEPTH));
    assign o_ovf      = i_push & o_full;
    assign o_unf      = i_pop & o_empty;
    assign w_do_pop   = i_pop & ~o_empty;

    // Pointer and occupancy bookkeeping; occupancy saturates at the depth
    // because a push into a full stack replaces the oldest entry.
    always_ff @(negedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_count <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + PTR_W'(1);
            if (!o_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_do_pop) begin
            r_ptr   <= w_ptr_prev;
            r_count <= r_count - CNT_W'(1);
        end
    end

    // Entry storage is never cleared: after reset the occupancy count says
    // nothing is valid, so stale contents are never observed.
    always_ff @(negedge i_clk) begin
        if (i_push && !i_rst) begin
            r_mem[r_ptr] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_unit_ras.sv
// Program-counter unit at the head of fetch: priority-encodes redirect
// requests, holds the PC register and the sticky stack error flags, and
// delegates return-address storage to ras_stack. State moves on the falling
// clock edge to match the fetch timing of the core.
module pc_unit_ras
    import pc_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              PC_STEP   = 1,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int              RAS_DEPTH = 8
)(
    input  logic          CLK,
    input  logic          RST,
    pc_unit_ras_if.slave  bus
);
    npc_sel_e          w_sel;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] w_pop_data;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic              w_full;
    logic              w_ovf_evt;
    logic              w_unf_evt;
    logic              r_ovf;
    logic              r_unf;

    assign w_pc_inc = r_pc + ADDR_W'(PC_STEP);

    // Pick exactly one PC source; halt outranks every redirect, and return
    // outranks call so a simultaneous call/return behaves as a plain return.
    always_comb begin
        w_sel = NPC_SEQ;
        if (bus.HLT) begin
            w_sel = NPC_HOLD;
        end else if (bus.RET) begin
            w_sel = NPC_RET;
        end else if (bus.CALL) begin
            w_sel = NPC_CALL;
        end else if (bus.JMP) begin
            w_sel = NPC_JMP;
        end else if (bus.BR_TAKEN) begin
            w_sel = NPC_BR;
        end
    end

    assign w_push = (w_sel == NPC_CALL);
    assign w_pop  = (w_sel == NPC_RET);

    // Next-PC mux; a return on an empty stack falls through to sequential.
    always_comb begin
        w_pc_next = w_pc_inc;
        case (w_sel)
            NPC_SEQ:  w_pc_next = w_pc_inc;
            NPC_BR:   w_pc_next = bus.BR_TARGET;
            NPC_JMP:  w_pc_next = bus.J_TARGET;
            NPC_CALL: w_pc_next = bus.J_TARGET;
            NPC_RET:  w_pc_next = w_empty ? w_pc_inc : w_pop_data;
            NPC_HOLD: w_pc_next = r_pc;
            default:  w_pc_next = w_pc_inc;
        endcase
    end

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .i_clk       (CLK),
        .i_rst       (RST),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_pc_inc),
        .o_pop_data  (w_pop_data),
        .o_empty     (w_empty),
        .o_full      (w_full),
        .o_ovf       (w_ovf_evt),
        .o_unf       (w_unf_evt)
    );

    // PC register and sticky error flags; a halt produces no push/pop and
    // selects the current PC, so everything holds without a separate enable.
    always_ff @(negedge CLK) begin
        if (RST) begin
            r_pc  <= RESET_VEC;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
            r_ovf <= r_ovf | w_ovf_evt;
            r_unf <= r_unf | w_unf_evt;
        end
    end

    assign bus.PC_OUT    = r_pc;
    assign bus.RAS_EMPTY = w_empty;
    assign bus.RAS_FULL  = w_full;
    assign bus.RAS_OVF   = r_ovf;
    assign bus.RAS_UNF   = r_unf;

endmodule

// File: tb/tb_pc_unit_ras.sv
// Directed bench for pc_unit_ras: a 32-bit instance for the functional
// sequences and an 8-bit instance for address wrap-around.
module tb_pc_unit_ras;

    logic clk;
    logic rst;
    int   compareCount;
    int   mismatchCount;

    pc_unit_ras_if #(.ADDR_W(32)) bus  ();
    pc_unit_ras_if #(.ADDR_W(8))  bus8 ();

    pc_unit_ras #(
        .ADDR_W    (32),
        .PC_STEP   (1),
        .RESET_VEC (32'h0),
        .RAS_DEPTH (8)
    ) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    pc_unit_ras #(
        .ADDR_W    (8),
        .PC_STEP   (1),
        .RESET_VEC (8'h0),
        .RAS_DEPTH (8)
    ) u_dut8 (
        .CLK (clk),
        .RST (rst),
        .bus (bus8)
    );

    // Free-running clock; the DUT updates on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one set of controls onto the chosen instance (the other idles),
    // let one falling edge act on it, then settle before any checks.
    task automatic applyStimulus(input logic sel8, input logic hlt,
                                 input logic br, input logic [31:0] brt,
                                 input logic jmp, input logic call,
                                 input logic [31:0] jt, input logic ret);
        @(posedge clk);
        bus.HLT  = sel8 ? 1'b0 : hlt;   bus8.HLT  = sel8 ? hlt  : 1'b0;
        bus.BR_TAKEN = sel8 ? 1'b0 : br; bus8.BR_TAKEN = sel8 ? br : 1'b0;
        bus.JMP  = sel8 ? 1'b0 : jmp;   bus8.JMP  = sel8 ? jmp  : 1'b0;
        bus.CALL = sel8 ? 1'b0 : call;  bus8.CALL = sel8 ? call : 1'b0;
        bus.RET  = sel8 ? 1'b0 : ret;   bus8.RET  = sel8 ? ret  : 1'b0;
        bus.BR_TARGET  = brt;
        bus.J_TARGET   = jt;
        bus8.BR_TARGET = brt[7:0];
        bus8.J_TARGET  = jt[7:0];
        @(negedge clk);
        #1;
    endtask

    // Convenience wrappers for the 32-bit instance.
    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic jumpTo(input logic [31:0] t);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, t, 1'b0);
    endtask

    task automatic callTo(input logic [31:0] t);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, t, 1'b0);
    endtask

    task automatic doRet();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    // Main directed sequence.
    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        rst = 1'b1;

        // Reset, with a jump request that reset must override.
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h99, 1'b0);
        rst = 1'b0;
        checkOutput("rst_pc",    bus.PC_OUT, 32'h0);
        checkOutput("rst_empty", 32'(bus.RAS_EMPTY), 32'h1);
        checkOutput("rst_full",  32'(bus.RAS_FULL),  32'h0);
        checkOutput("rst_ovf",   32'(bus.RAS_OVF),   32'h0);
        checkOutput("rst_unf",   32'(bus.RAS_UNF),   32'h0);

        // Sequential fetch.
        for (int i = 1; i <= 3; i++) begin
            idle();
            checkOutput("seq_pc", bus.PC_OUT, 32'(i));
        end
        checkOutput("seq_empty", 32'(bus.RAS_EMPTY), 32'h1);

        // Jump outranks branch; branch alone redirects.
        jumpTo(32'h5);
        checkOutput("jmp_pc5", bus.PC_OUT, 32'h5);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h80, 1'b0);
        checkOutput("br_jmp_prio", bus.PC_OUT, 32'h80);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h80, 1'b0);
        checkOutput("br_only", bus.PC_OUT, 32'h40);

        // Simple call / return.
        jumpTo(32'h10);
        callTo(32'h100);
        checkOutput("call_pc",    bus.PC_OUT, 32'h100);
        checkOutput("call_empty", 32'(bus.RAS_EMPTY), 32'h0);
        idle();
        idle();
        checkOutput("call_seq", bus.PC_OUT, 32'h102);
        doRet();
        checkOutput("ret_pc",    bus.PC_OUT, 32'h11);
        checkOutput("ret_empty", 32'(bus.RAS_EMPTY), 32'h1);

        // Nine calls into an eight-deep stack: call i pushes 0x201 + 16*i.
        for (int i = 0; i < 9; i++) begin
            jumpTo(32'h200 + 32'(i * 16));
            callTo(32'h1000);
            if (i == 7) begin
                checkOutput("full8_full", 32'(bus.RAS_FULL), 32'h1);
                checkOutput("full8_ovf",  32'(bus.RAS_OVF),  32'h0);
            end
        end
        checkOutput("ovf_full", 32'(bus.RAS_FULL), 32'h1);
        checkOutput("ovf_flag", 32'(bus.RAS_OVF),  32'h1);
        for (int k = 0; k < 8; k++) begin
            doRet();
            checkOutput("ovf_lifo", bus.PC_OUT, 32'h201 + 32'((8 - k) * 16));
        end
        checkOutput("ovf_drained", 32'(bus.RAS_EMPTY), 32'h1);
        checkOutput("ovf_sticky",  32'(bus.RAS_OVF),   32'h1);

        // Return on an empty stack behaves sequentially and flags underflow.
        jumpTo(32'h20);
        doRet();
        checkOutput("unf_pc",   bus.PC_OUT, 32'h21);
        checkOutput("unf_flag", 32'(bus.RAS_UNF), 32'h1);

        // Halt with a call pending: nothing may move.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 1'b0);
        end
        checkOutput("hlt_pc",    bus.PC_OUT, 32'h21);
        checkOutput("hlt_empty", 32'(bus.RAS_EMPTY), 32'h1);
        checkOutput("hlt_unf",   32'(bus.RAS_UNF),   32'h1);
        checkOutput("hlt_ovf",   32'(bus.RAS_OVF),   32'h1);

        // Simultaneous call and return: return wins, call is dropped.
        callTo(32'h500);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h600, 1'b1);
        checkOutput("callret_pc",    bus.PC_OUT, 32'h22);
        checkOutput("callret_empty", 32'(bus.RAS_EMPTY), 32'h1);

        // Reset mid-operation with a live entry clears flags and the stack.
        callTo(32'h700);
        checkOutput("pre_rst_empty", 32'(bus.RAS_EMPTY), 32'h0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        checkOutput("rst2_pc",    bus.PC_OUT, 32'h0);
        checkOutput("rst2_unf",   32'(bus.RAS_UNF),   32'h0);
        checkOutput("rst2_ovf",   32'(bus.RAS_OVF),   32'h0);
        checkOutput("rst2_empty", 32'(bus.RAS_EMPTY), 32'h1);
        doRet();
        checkOutput("rst2_ret_pc", bus.PC_OUT, 32'h1);

        // 8-bit instance: silent wrap at the top of the address space.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFF, 1'b0);
        checkOutput("w8_ff", 32'(bus8.PC_OUT), 32'hFF);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        checkOutput("w8_wrap", 32'(bus8.PC_OUT), 32'h00);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'hFF, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h40, 1'b0);
        checkOutput("w8_call", 32'(bus8.PC_OUT), 32'h40);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        checkOutput("w8_ret",   32'(bus8.PC_OUT), 32'h00);
        checkOutput("w8_empty", 32'(bus8.RAS_EMPTY), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
- Parametrised program-counter unit for the miniRISC core. Generalises the plain PC register with:
  - configurable address width, step and reset vector;
  - branch, jump, call and return next-PC selection;
  - an internal circular return-address stack (RAS) with occupancy and sticky error flags.
- Sits at the head of instruction fetch. PC_OUT drives instruction-memory addressing. Control inputs come from the decode/branch unit.

Parameters:
- ADDR_W, 32, width of PC and all address ports.
- PC_STEP, 1, sequential increment (word-addressed instruction memory).
- RESET_VEC, 0, PC value after reset; ADDR_W bits wide.
- RAS_DEPTH, 8, return-stack entries; power of two, minimum 2.

Ports:
- CLK  in  1  single clock; all state updates on the falling edge, matching the fetch timing of the existing core.
- RST  in  1  synchronous, active-high reset, sampled on the same edge.
- HLT  in  1  freeze all state: PC, RAS and flags.
- BR_TAKEN  in  1  conditional branch resolved taken.
- BR_TARGET  in  ADDR_W  branch destination.
- JMP  in  1  unconditional jump.
- CALL  in  1  jump and push return address.
- J_TARGET  in  ADDR_W  destination for JMP and CALL.
- RET  in  1  pop RAS into PC.
- PC_OUT  out  ADDR_W  current PC, driven directly from the register.
- RAS_EMPTY  out  1  occupancy == 0.
- RAS_FULL  out  1  occupancy == RAS_DEPTH.
- RAS_OVF  out  1  sticky: CALL issued while full.
- RAS_UNF  out  1  sticky: RET issued while empty.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-high.
  - RST has top priority over every other input.
- Reset values: PC_OUT=RESET_VEC, occupancy=0, stack pointer=0, RAS_EMPTY=1, RAS_FULL=0, RAS_OVF=0, RAS_UNF=0.
- Reset mid-operation discards all stack contents. Stale entry contents are don't-care.
- Update priority per edge: RST > HLT > RET > CALL > JMP > BR_TAKEN > sequential.
- HLT=1: nothing changes, including flags. Held requests are lost; the upstream stage holds its controls.
- Sequential update: PC <= PC + PC_STEP, modulo 2^ADDR_W. Wrap-around at the top of the address space is silent.
- BR_TAKEN: PC <= BR_TARGET.
- JMP: PC <= J_TARGET.
- CALL:
  - push PC + PC_STEP (modulo) at the stack pointer, advance the pointer modulo RAS_DEPTH;
  - PC <= J_TARGET;
  - occupancy increments, saturating at RAS_DEPTH.
- CALL when full: the push overwrites the oldest entry (circular), occupancy stays RAS_DEPTH, RAS_OVF set.
- RET with occupancy > 0: retreat the pointer, PC <= popped entry, occupancy decrements.
- RET when empty:
  - PC <= PC + PC_STEP; pointer and occupancy unchanged; RAS_UNF set.
- Simultaneous CALL and RET: RET wins, CALL ignored.
- Lower-priority requests asserted together with a higher one are ignored.
- Latency: the new PC is visible on PC_OUT immediately after the updating edge. No combinational path from any input to PC_OUT.
- Sticky flags clear only on RST.
- RAS_EMPTY and RAS_FULL are derived from registered occupancy.

Decomposition:
- Shared package pc_pkg holds:
  - next-PC select encoding NPC_SEQ, NPC_BR, NPC_JMP, NPC_CALL, NPC_RET, NPC_HOLD;
  - a clog2-based pointer-width helper constant.
- Sub-module ras_stack (parameters ADDR_W, RAS_DEPTH):
  - circular push/pop storage with pointer, occupancy, full/empty and overflow/underflow indications;
  - the top level keeps the priority encoder, PC register and sticky flags.

Test Plan:
- Reset and sequential fetch: RST=1 for 1 edge, then 3 idle edges -> PC_OUT 0,1,2,3; RAS_EMPTY=1.
- Branch vs jump priority: PC=5; BR_TAKEN=1 with BR_TARGET=0x40 and JMP=1 with J_TARGET=0x80 on the same edge -> PC=0x80. Next edge, BR only -> PC=0x40.
- Call/return:
  - PC=0x10; CALL with J_TARGET=0x100 -> PC=0x100, occupancy 1;
  - 2 sequential edges -> PC=0x102;
  - RET -> PC=0x11, RAS_EMPTY=1.
- Overflow wrap (RAS_DEPTH=8):
  - 9 CALLs from distinct PCs -> RAS_FULL=1, RAS_OVF=1;
  - 8 RETs return the newest 8 addresses in LIFO order; the first call's address is lost.
- Underflow and halt:
  - RET when empty at PC=0x20 -> PC=0x21, RAS_UNF=1.
  - HLT=1 for 4 edges with CALL=1 -> PC, occupancy and flags unchanged.
  - RST clears RAS_UNF.
- Address wrap (ADDR_W=8): PC=0xFF, idle edge -> PC=0x00. CALL at PC=0xFF pushes 0x00.
